tc_program_loader: RTL and testbench

Byte-stream loader that fills the program memory read by the fetch path. It accepts framed bytes over a valid/ready stream and parses a header giving start address and length. It then issues one byte-wide write per data byte to the program memory write port, and reports done/error to the host side. It sits between the host/UART byte source and the program memory's write port.

---
 rtl/tc_program_loader_if.sv | 26 ++
 rtl/tc_program_loader.sv | 151 +++++++++++++++
 tb/tb_tc_program_loader.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_program_loader_if.sv
// Loader bundle: host byte stream in, program-memory write port and load status out.
// The slave modport is the loader; the master modport is the host/bench side.
interface tc_program_loader_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_data;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [ADDR_WIDTH:0]   bytes_loaded;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_data, busy, done, error, bytes_loaded
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_data, busy, done, error, bytes_loaded
   );
endinterface

// File: rtl/tc_program_loader.sv
// Framed byte-stream loader writing program memory one byte per accepted data byte.
// Define PROGLOAD_CHECKSUM_EN to require and verify a trailing 8-bit checksum byte.
module tc_program_loader #(
   parameter int         ADDR_WIDTH = 16,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic               clk,
   input  logic               rst,
   tc_program_loader_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

`ifdef PROGLOAD_CHECKSUM_EN
   localparam state_t S_TAIL = S_CSUM;
   logic [7:0] csum_q, csum_d;
   logic [7:0] csum_chk;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t                state_q, state_d;
   logic [15:0]           start_q, start_d;
   logic [15:0]           len_q, len_d;
   logic [15:0]           idx_q, idx_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]            mem_data_q, mem_data_d;
   logic                  error_q, error_d;
   logic [ADDR_WIDTH:0]   bl_q, bl_d;
   logic                  in_ready;
   logic                  accept;

   assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
   assign accept   = bus.in_valid & in_ready;
`ifdef PROGLOAD_CHECKSUM_EN
   assign csum_chk = csum_q + bus.in_data;
`endif

   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      len_d      = len_q;
      idx_d      = idx_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      error_d    = error_q;
      bl_d       = bl_q;
`ifdef PROGLOAD_CHECKSUM_EN
      csum_d = csum_q;
      if (accept && (state_q inside {S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA}))
         csum_d = csum_q + bus.in_data;
`endif
      case (state_q)
         S_IDLE: begin
            // Anything other than the sync marker is swallowed here.
            if (accept && (bus.in_data == SYNC_BYTE)) begin
               state_d = S_ADDR_LO;
               error_d = 1'b0;
               bl_d    = '0;
               idx_d   = '0;
`ifdef PROGLOAD_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_ADDR_LO: if (accept) begin
            start_d[7:0] = bus.in_data;
            state_d      = S_ADDR_HI;
         end
         S_ADDR_HI: if (accept) begin
            start_d[15:8] = bus.in_data;
            state_d       = S_LEN_LO;
         end
         S_LEN_LO: if (accept) begin
            len_d[7:0] = bus.in_data;
            state_d    = S_LEN_HI;
         end
         S_LEN_HI: if (accept) begin
            len_d[15:8] = bus.in_data;
            state_d     = ({bus.in_data, len_q[7:0]} == 16'h0000) ? S_TAIL : S_DATA;
         end
         S_DATA: if (accept) begin
            // Address arithmetic is modulo 2^ADDR_WIDTH, so wrap past the top is silent.
            mem_we_d   = 1'b1;
            mem_data_d = bus.in_data;
            mem_addr_d = ADDR_WIDTH'(start_q) + ADDR_WIDTH'(idx_q);
            bl_d       = bl_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            idx_d      = idx_q + 16'd1;
            if (idx_q == (len_q - 16'd1))
               state_d = S_TAIL;
         end
`ifdef PROGLOAD_CHECKSUM_EN
         S_CSUM: if (accept) begin
            if (csum_chk == 8'h00) begin
               state_d = S_DONE;
            end else begin
               state_d = S_ERR;
               error_d = 1'b1;
            end
         end
         S_ERR:  state_d = S_IDLE;
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         start_q    <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         error_q    <= 1'b0;
         bl_q       <= '0;
`ifdef PROGLOAD_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         error_q    <= error_d;
         bl_q       <= bl_d;
`ifdef PROGLOAD_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_data     = mem_data_q;
   assign bus.busy         = !(state_q inside {S_IDLE, S_DONE, S_ERR});
   assign bus.done         = (state_q == S_DONE);
   assign bus.error        = error_q;
   assign bus.bytes_loaded = bl_q;

endmodule

// File: tb/tb_tc_program_loader.sv
// Randomized self-checking bench for tc_program_loader against a frame-level parser model.
// Follows PROGLOAD_CHECKSUM_EN so the same bench covers both builds.
module tb_tc_program_loader;
   localparam int         AW   = 16;
   localparam logic [7:0] SYNC = 8'hA5;
`ifdef PROGLOAD_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   tc_program_loader_if #(.ADDR_WIDTH(AW)) bus ();
   tc_program_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: log every write with its cycle and count status events.
   logic [15:0] got_a[$];
   logic [7:0]  got_d[$];
   int          got_c[$];
   int          n_done = 0, n_rdy_low = 0, n_done_bad = 0, n_hold = 0;
   logic [15:0] prev_a;
   logic [7:0]  prev_d;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_we === 1'b1) begin
            got_a.push_back(bus.mem_addr);
            got_d.push_back(bus.mem_data);
            got_c.push_back(cyc);
         end else if (bus.mem_addr !== prev_a || bus.mem_data !== prev_d) begin
            n_hold++;
         end
         if (bus.done === 1'b1) begin
            n_done++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) n_done_bad++;
         end
         if (bus.in_ready !== 1'b1) n_rdy_low++;
      end
      prev_a = bus.mem_addr;
      prev_d = bus.mem_data;
   end

   // Stimulus stream and reference results.
   logic [7:0]  stim[$];
   int          acc_c[256];
   logic [15:0] exp_a[$];
   logic [7:0]  exp_d[$];
   int          exp_done, exp_ends, exp_bl;
   logic        exp_err;
   int          bw, bd, br, bh, bb;

   function automatic void add_frame(input logic [15:0] a, input int len);
      logic [7:0] sum;
      logic [7:0] b;
      stim.push_back(SYNC);
      stim.push_back(a[7:0]);
      stim.push_back(a[15:8]);
      stim.push_back(8'(len));
      stim.push_back(8'(len >> 8));
      sum = a[7:0] + a[15:8] + 8'(len) + 8'(len >> 8);
      for (int k = 0; k < len; k++) begin
         b = 8'($urandom_range(255, 0));
         stim.push_back(b);
         sum = sum + b;
      end
      if (CSUM_EN) stim.push_back(8'h00 - sum);
   endfunction

   // Parse the whole byte stream frame by frame and list what the loader must do.
   function automatic void model();
      int          i;
      int          n;
      logic [15:0] a;
      logic [15:0] len;
      logic [7:0]  sum;
      bit          ok;
      exp_a.delete();
      exp_d.delete();
      exp_done = 0; exp_ends = 0; exp_bl = 0; exp_err = 1'b0;
      n = stim.size();
      i = 0;
      while (i < n) begin
         if (stim[i] !== SYNC) begin
            i++;
            continue;
         end
         i++;
         exp_err = 1'b0;
         exp_bl  = 0;
         if (i + 4 > n) break;
         a   = {stim[i+1], stim[i]};
         len = {stim[i+3], stim[i+2]};
         sum = stim[i] + stim[i+1] + stim[i+2] + stim[i+3];
         i += 4;
         ok = 1'b1;
         for (int k = 0; k < int'(len); k++) begin
            if (i >= n) begin
               ok = 1'b0;
               break;
            end
            exp_a.push_back(a + 16'(k));
            exp_d.push_back(stim[i]);
            sum = sum + stim[i];
            exp_bl++;
            i++;
         end
         if (!ok) break;
         if (CSUM_EN) begin
            if (i >= n) break;
            if (8'(sum + stim[i]) == 8'h00) exp_done++;
            else exp_err = 1'b1;
            exp_ends++;
            i++;
         end else begin
            exp_done++;
            exp_ends++;
         end
      end
   endfunction

   task automatic snap();
      bw = got_a.size(); bd = n_done; br = n_rdy_low; bh = n_hold; bb = n_done_bad;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic send_stream(input int from, input int to, input int gapmax);
      int t;
      int g;
      for (int i = from; i < to; i++) begin
         g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
         repeat (g) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
         end
         t = 0;
         forever begin
            @(negedge clk);
            bus.in_data  = stim[i];
            bus.in_valid = 1'b1;
            if (bus.in_ready === 1'b1) break;
            t++;
            if (t > 20) break;
         end
         if (t > 20) begin
            checks++; errors++;
            $display("FAIL handshake_timeout byte %0d in_ready=%b required 1", i, bus.in_ready);
         end
         acc_c[i] = cyc + 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      idle(3);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.error, bus.bytes_loaded} !== '0) begin
         errors++;
         $display("FAIL reset_outputs we=%b addr=%h data=%h busy=%b done=%b err=%b bl=%0d required all 0",
                  bus.mem_we, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.error, bus.bytes_loaded);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_basic();
      stim = '{8'hA5, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h87};
      model();
      snap();
      send_stream(0, stim.size(), 0);
      idle(6);
      checks++;
      if (got_a.size() - bw !== exp_a.size()) begin
         errors++; $display("FAIL basic_write_count got %0d required %0d", got_a.size() - bw, exp_a.size());
      end else begin
         for (int i = 0; i < exp_a.size(); i++) begin
            checks++;
            if (got_a[bw+i] !== exp_a[i] || got_d[bw+i] !== exp_d[i] || got_c[bw+i] !== acc_c[5+i]) begin
               errors++;
               $display("FAIL basic_write%0d got %h<-%h @%0d required %h<-%h @%0d", i,
                        got_a[bw+i], got_d[bw+i], got_c[bw+i], exp_a[i], exp_d[i], acc_c[5+i]);
            end
         end
      end
      checks++;
      if (n_done - bd !== exp_done || bus.error !== exp_err || bus.bytes_loaded !== 17'(exp_bl)) begin
         errors++;
         $display("FAIL basic_status done=%0d err=%b bl=%0d required done=%0d err=%b bl=%0d",
                  n_done - bd, bus.error, bus.bytes_loaded, exp_done, exp_err, exp_bl);
      end
      checks++;
      if (n_hold - bh !== 0 || n_done_bad - bb !== 0) begin
         errors++; $display("FAIL basic_hold_or_done_cycle hold=%0d donebad=%0d required 0 0", n_hold - bh, n_done_bad - bb);
      end
   endtask

   task automatic test_bad_checksum();
      stim = '{8'hA5, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h86};
      model();
      snap();
      send_stream(0, stim.size(), 0);
      idle(6);
      checks++;
      if (got_a.size() - bw !== exp_a.size() || n_done - bd !== exp_done || bus.error !== exp_err) begin
         errors++;
         $display("FAIL badcsum_result writes=%0d done=%0d err=%b required writes=%0d done=%0d err=%b",
                  got_a.size() - bw, n_done - bd, bus.error, exp_a.size(), exp_done, exp_err);
      end
      idle(10);
      checks++;
      if (bus.error !== exp_err) begin
         errors++; $display("FAIL badcsum_sticky err=%b required %b", bus.error, exp_err);
      end
      stim.delete();
      add_frame(16'h0100, 2);
      model();
      snap();
      send_stream(0, 1, 0);
      idle(2);
      checks++;
      if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL badcsum_sync_clears err=%b busy=%b required 0 1", bus.error, bus.busy);
      end
      send_stream(1, stim.size(), 0);
      idle(6);
      checks++;
      if (got_a.size() - bw !== exp_a.size() || n_done - bd !== exp_done || bus.error !== exp_err) begin
         errors++;
         $display("FAIL badcsum_next_frame writes=%0d done=%0d err=%b required writes=%0d done=%0d err=%b",
                  got_a.size() - bw, n_done - bd, bus.error, exp_a.size(), exp_done, exp_err);
      end
   endtask

   task automatic test_wrap();
      stim = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h9B};
      model();
      snap();
      send_stream(0, stim.size(), 0);
      idle(6);
      checks++;
      if (got_a.size() - bw !== 2) begin
         errors++; $display("FAIL wrap_write_count got %0d required 2", got_a.size() - bw);
      end else begin
         checks++;
         if (got_a[bw] !== 16'hFFFF || got_d[bw] !== 8'hAA || got_a[bw+1] !== 16'h0000 || got_d[bw+1] !== 8'hBB) begin
            errors++;
            $display("FAIL wrap_writes got %h<-%h %h<-%h required ffff<-aa 0000<-bb",
                     got_a[bw], got_d[bw], got_a[bw+1], got_d[bw+1]);
         end
      end
      checks++;
      if (n_done - bd !== exp_done || bus.error !== exp_err) begin
         errors++; $display("FAIL wrap_done done=%0d err=%b required %0d %b", n_done - bd, bus.error, exp_done, exp_err);
      end
   endtask

   task automatic test_zero_len_junk();
      stim = '{8'h00, 8'h5A, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFF};
      model();
      snap();
      send_stream(0, stim.size(), 0);
      idle(6);
      checks++;
      if (got_a.size() - bw !== 0 || n_done - bd !== 1 || bus.error !== 1'b0 || bus.bytes_loaded !== '0) begin
         errors++;
         $display("FAIL zero_len writes=%0d done=%0d err=%b bl=%0d required 0 1 0 0",
                  got_a.size() - bw, n_done - bd, bus.error, bus.bytes_loaded);
      end
      checks++;
      if (n_rdy_low - br !== exp_ends) begin
         errors++; $display("FAIL zero_len_ready_low got %0d required %0d", n_rdy_low - br, exp_ends);
      end
   endtask

   task automatic test_backpressure();
      stim.delete();
      add_frame(16'($urandom_range(16'hFFFF, 0)), 16);
      model();
      snap();
      send_stream(0, stim.size(), 3);
      idle(6);
      checks++;
      if (got_a.size() - bw !== 16 || exp_a.size() !== 16) begin
         errors++; $display("FAIL stall_write_count got %0d required 16", got_a.size() - bw);
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_a[bw+i] !== exp_a[i] || got_d[bw+i] !== exp_d[i]) begin
               errors++;
               $display("FAIL stall_write%0d got %h<-%h required %h<-%h", i, got_a[bw+i], got_d[bw+i], exp_a[i], exp_d[i]);
            end
         end
      end
      checks++;
      if (n_rdy_low - br !== exp_ends || n_done_bad - bb !== 0 || n_done - bd !== exp_done) begin
         errors++;
         $display("FAIL stall_ready rdylow=%0d donebad=%0d done=%0d required %0d 0 %0d",
                  n_rdy_low - br, n_done_bad - bb, n_done - bd, exp_ends, exp_done);
      end
      checks++;
      if (bus.bytes_loaded !== 17'd16 || n_hold - bh !== 0) begin
         errors++; $display("FAIL stall_count bl=%0d hold=%0d required 16 0", bus.bytes_loaded, n_hold - bh);
      end
   endtask

   task automatic test_back_to_back();
      stim.delete();
      for (int f = 0; f < 3; f++) add_frame(16'($urandom_range(16'hFFFF, 0)), int'($urandom_range(6, 1)));
      model();
      snap();
      send_stream(0, stim.size(), 0);
      idle(6);
      checks++;
      if (got_a.size() - bw !== exp_a.size()) begin
         errors++; $display("FAIL b2b_write_count got %0d required %0d", got_a.size() - bw, exp_a.size());
      end else begin
         for (int i = 0; i < exp_a.size(); i++) begin
            checks++;
            if (got_a[bw+i] !== exp_a[i] || got_d[bw+i] !== exp_d[i]) begin
               errors++;
               $display("FAIL b2b_write%0d got %h<-%h required %h<-%h", i, got_a[bw+i], got_d[bw+i], exp_a[i], exp_d[i]);
            end
         end
      end
      checks++;
      if (n_done - bd !== exp_done || bus.bytes_loaded !== 17'(exp_bl) || n_rdy_low - br !== exp_ends) begin
         errors++;
         $display("FAIL b2b_status done=%0d bl=%0d rdylow=%0d required %0d %0d %0d",
                  n_done - bd, bus.bytes_loaded, n_rdy_low - br, exp_done, exp_bl, exp_ends);
      end
   endtask

   task automatic test_reset_mid_frame();
      stim.delete();
      add_frame(16'h2000, 16);
      send_stream(0, 7, 0);
      idle(2);
      checks++;
      if (bus.bytes_loaded !== 17'd2 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL midrst_pre bl=%0d busy=%b required 2 1", bus.bytes_loaded, bus.busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.error, bus.bytes_loaded} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs we=%b addr=%h data=%h busy=%b done=%b err=%b bl=%0d required all 0",
                  bus.mem_we, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.error, bus.bytes_loaded);
      end
      @(negedge clk);
      rst = 1'b0;
      stim.delete();
      add_frame(16'($urandom_range(16'hFFFF, 0)), 5);
      model();
      snap();
      send_stream(0, stim.size(), 1);
      idle(6);
      checks++;
      if (got_a.size() - bw !== exp_a.size()) begin
         errors++; $display("FAIL midrst_write_count got %0d required %0d", got_a.size() - bw, exp_a.size());
      end else begin
         for (int i = 0; i < exp_a.size(); i++) begin
            checks++;
            if (got_a[bw+i] !== exp_a[i] || got_d[bw+i] !== exp_d[i]) begin
               errors++;
               $display("FAIL midrst_write%0d got %h<-%h required %h<-%h", i, got_a[bw+i], got_d[bw+i], exp_a[i], exp_d[i]);
            end
         end
      end
      checks++;
      if (n_done - bd !== exp_done || bus.bytes_loaded !== 17'(exp_bl) || bus.error !== exp_err) begin
         errors++;
         $display("FAIL midrst_status done=%0d bl=%0d err=%b required %0d %0d %b",
                  n_done - bd, bus.bytes_loaded, bus.error, exp_done, exp_bl, exp_err);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_bad_checksum();
      test_wrap();
      test_zero_len_junk();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
